// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: op encodings, FSM state type and counter-width helper shared
// by the sequential ALU and its iterative multiply/divide unit.
package alu_seq_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Smallest r with 2**r >= n; sizes the iteration counter.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: start/busy/done request bus of the sequential ALU.
// The master drives operands and start; the slave (the ALU) returns status
// and the registered result.
interface alu_seq_if #(
  parameter int WIDTH = 6
) ();
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2:0]         func;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] out;
  logic               err;

  modport master (output start, a, b, func, input busy, done, out, err);
  modport slave  (input start, a, b, func, output busy, done, out, err);
endinterface

// File: rtl/alu_seq_muldiv.sv
// seq_muldiv: iterative shift-add multiplier / restoring divider.
// One shared 2*WIDTH accumulator holds {hi, lo} of the product or
// {remainder, quotient} of the division. The divider path is compiled in
// only when ALU_DIV_EN is defined. `result` is the accumulator after the
// step of the current cycle, so the owner can capture it on the cycle
// `last` is high.
module seq_muldiv
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q, acc_d, step;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     mul_sum;

`ifdef ALU_DIV_EN
  logic               div_q, div_d;
  logic [WIDTH:0]     div_trial, div_diff;
`else
  logic               unused_is_div;
  assign unused_is_div = is_div;
`endif

  assign last   = (cnt_q == CW'(WIDTH - 1));
  assign result = step;

  // One iteration: add-and-shift for mul, trial-subtract-and-shift for div.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    step    = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_trial - {1'b0, opnd_q};
    if (div_q) begin
      // A set top bit means the trial went negative: restore and shift in 0.
      if (div_diff[WIDTH]) step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      else                 step = {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
    end
`endif
  end

  // Next-state: load on go, otherwise step until the counter hits its last value.
  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
`ifdef ALU_DIV_EN
    div_d  = div_q;
`endif
    if (go) begin
      cnt_d = '0;
`ifdef ALU_DIV_EN
      div_d = is_div;
      if (is_div) begin
        acc_d  = {{WIDTH{1'b0}}, a};
        opnd_d = b;
      end else begin
        acc_d  = {{WIDTH{1'b0}}, b};
        opnd_d = a;
      end
`else
      acc_d  = {{WIDTH{1'b0}}, b};
      opnd_d = a;
`endif
    end else if (!last) begin
      acc_d = step;
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
`ifdef ALU_DIV_EN
      div_q  <= 1'b0;
`endif
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
`ifdef ALU_DIV_EN
      div_q  <= div_d;
`endif
    end
  end

endmodule

// File: rtl/alu_seq_top.sv
// alu_seq_top: sequential ALU with start/busy/done handshake.
// add/sub/out_sel finish one cycle after acceptance; mul/div iterate WIDTH
// cycles in seq_muldiv. Divide support is compiled in with ALU_DIV_EN;
// without it func=11 completes at once with out=0, err=1.
//
//   state | meaning
//   IDLE  | waiting for start, or (pend_q set) dispatching a latched request
//   RUN   | iterative mul/div in progress, busy=1
//   DONE  | one-cycle done pulse; out/err just updated; may accept start
module alu_seq_top
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus
);

  state_t             state_q;
  logic               pend_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2:0]         func_q;
  logic [2*WIDTH-1:0] out_q;
  logic               err_q;

  logic               accept, is_mul, is_div, go, md_last;
  logic [2*WIDTH-1:0] md_result, sc_out;
  logic               sc_err;
  logic [WIDTH:0]     add_sum;

  // A request is taken in DONE, or in IDLE once the previous one is dispatched.
  assign accept = bus.start && (((state_q == IDLE) && !pend_q) || (state_q == DONE));

  assign is_mul = !func_q[2] && (func_q[1:0] == OP_MUL);
`ifdef ALU_DIV_EN
  assign is_div = !func_q[2] && (func_q[1:0] == OP_DIV) && (b_q != '0);
`else
  assign is_div = 1'b0;
`endif
  assign go = pend_q && (is_mul || is_div);

  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .go     (go),
    .is_div (is_div),
    .a      (a_q),
    .b      (b_q),
    .last   (md_last),
    .result (md_result)
  );

  // Single-cycle results from the latched operands.
  always_comb begin
    sc_out  = '0;
    sc_err  = 1'b0;
    add_sum = {1'b0, a_q} + {1'b0, b_q};
    if (func_q[2]) begin
      sc_out = {a_q, b_q};
    end else begin
      case (func_q[1:0])
        OP_ADD: sc_out = {{(WIDTH-1){1'b0}}, add_sum};
        OP_SUB: begin
          sc_out = {{WIDTH{1'b0}}, a_q - b_q};
          sc_err = (a_q < b_q);
        end
        OP_DIV: begin
          // Only reached for b==0 when the divider exists.
`ifdef ALU_DIV_EN
          sc_out = '1;
`else
          sc_out = '0;
`endif
          sc_err = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Control FSM with operand latch and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      func_q  <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= bus.a;
      b_q     <= bus.b;
      func_q  <= bus.func;
      pend_q  <= 1'b1;
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (pend_q) begin
            pend_q <= 1'b0;
            if (go) begin
              state_q <= RUN;
            end else begin
              state_q <= DONE;
              out_q   <= sc_out;
              err_q   <= sc_err;
            end
          end
        end
        RUN: begin
          if (md_last) begin
            state_q <= DONE;
            out_q   <= md_result;
            err_q   <= 1'b0;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.out  = out_q;
  assign bus.err  = err_q;

endmodule
